// File: rtl/imm_decode_pkg.sv
// Shared types and constants for the immediate-decode pipeline stage:
// base RV32I/RV64I major opcodes, the immediate format code and the
// XLEN-independent part of a pipeline entry.
package imm_decode_pkg;

  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;

  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_U     = 3'd3,
    IMM_J     = 3'd4,
    IMM_SHAMT = 3'd5,
    IMM_NONE  = 3'd6
  } imm_fmt_t;

  // Width-independent payload; the XLEN-wide fields live in the top module.
  typedef struct packed {
    logic [31:0] instr;
    imm_fmt_t    fmt;
    logic        illegal;
  } entry_meta_t;

  // funct3 encodings of the immediate shifts (slli/srli/srai and W forms).
  function automatic logic is_shift_funct3(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Handshake bundle of the immediate-decode stage: upstream valid/ready
// with instruction and PC, downstream valid/ready with the decoded entry.
// With IMM_TARGET_CALC_EN defined the bundle also carries out_target.
// XLEN must match the XLEN of the stage it is connected to.
interface imm_decode_stage_if #(
  parameter int XLEN = 32
);
  import imm_decode_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  imm_fmt_t        out_fmt;
  logic            out_illegal;
`ifdef IMM_TARGET_CALC_EN
  logic [XLEN-1:0] out_target;
`endif

  // Producer/consumer side (fetch upstream, register read downstream).
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
`ifdef IMM_TARGET_CALC_EN
    , input out_target
`endif
  );

  // The decode stage itself.
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
`ifdef IMM_TARGET_CALC_EN
    , output out_target
`endif
  );

endinterface

// File: rtl/imm_decode_stage_imm_extract.sv
// Purely combinational immediate extraction: classifies the instruction
// format from its opcode and produces the XLEN-wide immediate plus an
// illegal flag for opcodes (or shift amounts) this XLEN does not support.
module imm_extract
  import imm_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_t        fmt_o,
  output logic            illegal_o
);

  localparam int SHAMT_W = $clog2(XLEN);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [31:0] imm_j;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  // Raw 32-bit signed immediates; widened to XLEN with a signed size cast.
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  // Opcode classification and immediate selection.
  always_comb begin
    imm_o     = '0;
    fmt_o     = IMM_NONE;
    illegal_o = 1'b0;
    case (opcode)
      LUI, AUIPC: begin
        fmt_o = IMM_U;
        imm_o = XLEN'(imm_u);
      end
      JAL: begin
        fmt_o = IMM_J;
        imm_o = XLEN'(imm_j);
      end
      JALR, LOAD: begin
        fmt_o = IMM_I;
        imm_o = XLEN'(imm_i);
      end
      STORE: begin
        fmt_o = IMM_S;
        imm_o = XLEN'(imm_s);
      end
      BRANCH: begin
        fmt_o = IMM_B;
        imm_o = XLEN'(imm_b);
      end
      OP_IMM: begin
        if (is_shift_funct3(funct3)) begin
          // On RV32 bit 25 would be shamt[5], which does not exist.
          fmt_o     = IMM_SHAMT;
          imm_o     = XLEN'(instr_i[20 +: SHAMT_W]);
          illegal_o = (XLEN == 32) && instr_i[25];
        end else begin
          fmt_o = IMM_I;
          imm_o = XLEN'(imm_i);
        end
      end
      OP: begin
        fmt_o = IMM_NONE;
      end
      OP_IMM_32: begin
        if (XLEN == 64) begin
          if (is_shift_funct3(funct3)) begin
            // W-form shifts only have a 5-bit shift amount.
            fmt_o     = IMM_SHAMT;
            imm_o     = XLEN'(instr_i[24:20]);
            illegal_o = instr_i[25];
          end else begin
            fmt_o = IMM_I;
            imm_o = XLEN'(imm_i);
          end
        end else begin
          illegal_o = 1'b1;
        end
      end
      OP_32: begin
        illegal_o = (XLEN != 64);
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-generation stage between fetch and register read.
// One instruction+PC per handshake; one cycle later the stage presents the
// sign/zero-extended immediate, its format code and an illegal flag.
// A main register M drives the outputs and a skid register S absorbs the
// one entry that can arrive while M is stalled, so in_ready depends only on
// local state and full throughput is kept under out_ready=1.
// Optional build macro IMM_TARGET_CALC_EN adds out_target = pc + imm for
// AUIPC, JAL and branches, computed before the registers.
module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic              clk,
  input logic              reset,
  input logic              flush,
  imm_decode_stage_if.slave bus
);

  typedef struct packed {
    entry_meta_t     meta;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
`ifdef IMM_TARGET_CALC_EN
    logic [XLEN-1:0] target;
`endif
  } entry_t;

  logic [XLEN-1:0] ext_imm;
  imm_fmt_t        ext_fmt;
  logic            ext_illegal;

  entry_t in_entry;
  entry_t m_q, m_d;
  entry_t s_q, s_d;
  logic   m_valid_q, m_valid_d;
  logic   s_valid_q, s_valid_d;
  logic   accept;

  imm_extract #(
    .XLEN (XLEN)
  ) u_extract (
    .instr_i   (bus.in_instr),
    .imm_o     (ext_imm),
    .fmt_o     (ext_fmt),
    .illegal_o (ext_illegal)
  );

  assign accept = bus.in_valid && !s_valid_q;

  // Assemble the entry that would be captured this cycle.
  always_comb begin
    in_entry              = '0;
    in_entry.meta.instr   = bus.in_instr;
    in_entry.meta.fmt     = ext_fmt;
    in_entry.meta.illegal = ext_illegal;
    in_entry.pc           = bus.in_pc;
    in_entry.imm          = ext_imm;
`ifdef IMM_TARGET_CALC_EN
    if ((ext_fmt == IMM_J) || (ext_fmt == IMM_B) ||
        ((ext_fmt == IMM_U) && (bus.in_instr[6:0] == AUIPC))) begin
      in_entry.target = bus.in_pc + ext_imm;
    end
`endif
  end

  // M/S occupancy and data movement; flush wins over everything.
  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_d       = m_q;
    s_d       = s_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || bus.out_ready) begin
      // M is free this cycle: refill from S first to keep order.
      if (s_valid_q) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_d       = in_entry;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_d       = in_entry;
      s_valid_d = 1'b1;
    end
  end

  // State registers; reset discards both entries immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_q       <= '0;
      s_q       <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_q       <= m_d;
      s_q       <= s_d;
    end
  end

  assign bus.in_ready    = !s_valid_q;
  assign bus.out_valid   = m_valid_q;
  assign bus.out_instr   = m_q.meta.instr;
  assign bus.out_pc      = m_q.pc;
  assign bus.out_imm     = m_q.imm;
  assign bus.out_fmt     = m_q.meta.fmt;
  assign bus.out_illegal = m_q.meta.illegal;
`ifdef IMM_TARGET_CALC_EN
  assign bus.out_target  = m_q.target;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: an XLEN=32 and an XLEN=64 instance driven
// with identical stimulus. A fixed vector table, hand-written handshake
// sequences, and a random phase checked by a queue-based reference model.
module tb_imm_decode_stage;

  logic clk;
  logic reset;
  logic flush;

  int n_cmp  = 0;
  int n_fail = 0;

  imm_decode_stage_if #(.XLEN(32)) if32 ();
  imm_decode_stage_if #(.XLEN(64)) if64 ();

  imm_decode_stage #(.XLEN(32)) dut32 (.clk(clk), .reset(reset), .flush(flush), .bus(if32));
  imm_decode_stage #(.XLEN(64)) dut64 (.clk(clk), .reset(reset), .flush(flush), .bus(if64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    int          fmt;
    bit          ill;
    logic [63:0] tgt;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [31:0] imm32;
    int          fmt32;
    bit          ill32;
    logic [63:0] imm64;
    int          fmt64;
    bit          ill64;
    logic [63:0] tgt;
  } vec_t;

  exp_t q32[$];
  exp_t q64[$];
  vec_t tv[16];
  int   ops[12] = '{'h37, 'h17, 'h6F, 'h67, 'h63, 'h03, 'h23, 'h13, 'h33, 'h1B, 'h3B, 'h7F};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint sx(input longint val, input int bits);
    if (val >= (longint'(1) << (bits - 1))) return val - (longint'(1) << bits);
    return val;
  endfunction

  // Reference decode from the instruction-set rules, using plain arithmetic.
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc_in, input int xlen);
    exp_t        e;
    longint      v;
    logic [63:0] mask;
    int          op;
    int          f3;
    mask  = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    op    = int'(ins[6:0]);
    f3    = int'(ins[14:12]);
    v     = 0;
    e.fmt = 6;
    e.ill = 1'b0;
    case (op)
      'h37, 'h17: begin e.fmt = 3; v = sx(longint'(ins[31:12]) * 4096, 32); end
      'h6F: begin
        e.fmt = 4;
        v = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
               longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
      end
      'h63: begin
        e.fmt = 2;
        v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
               longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
      end
      'h23: begin e.fmt = 1; v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12); end
      'h67, 'h03: begin e.fmt = 0; v = sx(longint'(ins[31:20]), 12); end
      'h13: begin
        if (f3 == 1 || f3 == 5) begin
          e.fmt = 5;
          if (xlen == 32) begin v = longint'(ins[24:20]); e.ill = ins[25]; end
          else v = longint'(ins[25:20]);
        end else begin
          e.fmt = 0; v = sx(longint'(ins[31:20]), 12);
        end
      end
      'h33: e.fmt = 6;
      'h1B: begin
        if (xlen == 64) begin
          if (f3 == 1 || f3 == 5) begin e.fmt = 5; v = longint'(ins[24:20]); e.ill = ins[25]; end
          else begin e.fmt = 0; v = sx(longint'(ins[31:20]), 12); end
        end else e.ill = 1'b1;
      end
      'h3B: e.ill = (xlen != 64);
      default: e.ill = 1'b1;
    endcase
    e.instr = ins;
    e.pc    = pc_in & mask;
    e.imm   = 64'(v) & mask;
    e.tgt   = (op == 'h17 || op == 'h6F || op == 'h63) ? ((pc_in + e.imm) & mask) : 64'h0;
    return e;
  endfunction

  task automatic cmp32(input exp_t e);
    chk("sb32.instr", if32.out_instr, e.instr);
    chk("sb32.pc", if32.out_pc, e.pc);
    chk("sb32.imm", if32.out_imm, e.imm);
    chk("sb32.fmt", if32.out_fmt, e.fmt);
    chk("sb32.illegal", if32.out_illegal, e.ill);
`ifdef IMM_TARGET_CALC_EN
    chk("sb32.target", if32.out_target, e.tgt);
`endif
  endtask

  task automatic cmp64(input exp_t e);
    chk("sb64.instr", if64.out_instr, e.instr);
    chk("sb64.pc", if64.out_pc, e.pc);
    chk("sb64.imm", if64.out_imm, e.imm);
    chk("sb64.fmt", if64.out_fmt, e.fmt);
    chk("sb64.illegal", if64.out_illegal, e.ill);
`ifdef IMM_TARGET_CALC_EN
    chk("sb64.target", if64.out_target, e.tgt);
`endif
  endtask

  // Scoreboard for the 32-bit instance: occupancy model plus in-order queue.
  always @(negedge clk) begin
    int sz;
    if (reset) q32.delete();
    else begin
      sz = q32.size();
      chk("occ32.out_valid", if32.out_valid, 64'(sz != 0));
      chk("occ32.in_ready", if32.in_ready, 64'(sz < 2));
      if (flush) q32.delete();
      else begin
        if (sz != 0) begin
          if (if32.out_valid) cmp32(q32[0]);
          if (if32.out_ready) void'(q32.pop_front());
        end
        if (if32.in_valid && sz < 2) q32.push_back(model(if32.in_instr, 64'(if32.in_pc), 32));
      end
    end
  end

  // Scoreboard for the 64-bit instance.
  always @(negedge clk) begin
    int sz;
    if (reset) q64.delete();
    else begin
      sz = q64.size();
      chk("occ64.out_valid", if64.out_valid, 64'(sz != 0));
      chk("occ64.in_ready", if64.in_ready, 64'(sz < 2));
      if (flush) q64.delete();
      else begin
        if (sz != 0) begin
          if (if64.out_valid) cmp64(q64[0]);
          if (if64.out_ready) void'(q64.pop_front());
        end
        if (if64.in_valid && sz < 2) q64.push_back(model(if64.in_instr, if64.in_pc, 64));
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                       input bit rdy, input bit fl);
    if32.in_valid = v;  if32.in_instr = ins; if32.in_pc = pc[31:0]; if32.out_ready = rdy;
    if64.in_valid = v;  if64.in_instr = ins; if64.in_pc = pc;       if64.out_ready = rdy;
    flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] A = 32'h00100093;
  localparam logic [31:0] B = 32'h00200113;
  localparam logic [31:0] C = 32'h00300193;
  localparam logic [31:0] D = 32'h00400213;

  initial begin
    logic [31:0] ri;
    tv[0]  = '{32'h004D22B7, 64'h1000, 32'h004D2000, 3, 0, 64'h0000_0000_004D_2000, 3, 0, 64'h0};
    tv[1]  = '{32'h648190EF, 64'h1000, 32'h00019648, 4, 0, 64'h0000_0000_0001_9648, 4, 0, 64'h1A648};
    tv[2]  = '{32'h40628063, 64'h1000, 32'h00000400, 2, 0, 64'h0000_0000_0000_0400, 2, 0, 64'h1400};
    tv[3]  = '{32'h21D2A023, 64'h1000, 32'h00000200, 1, 0, 64'h0000_0000_0000_0200, 1, 0, 64'h0};
    tv[4]  = '{32'h005F9F93, 64'h1000, 32'h00000005, 5, 0, 64'h5, 5, 0, 64'h0};
    tv[5]  = '{32'hFFF00093, 64'h1000, 32'hFFFFFFFF, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'h0};
    tv[6]  = '{32'h02109093, 64'h1000, 32'h00000001, 5, 1, 64'h21, 5, 0, 64'h0};
    tv[7]  = '{32'h0000007F, 64'h1000, 32'h00000000, 6, 1, 64'h0, 6, 1, 64'h0};
    tv[8]  = '{32'h002081B3, 64'h1000, 32'h00000000, 6, 0, 64'h0, 6, 0, 64'h0};
    tv[9]  = '{32'hFFF0809B, 64'h1000, 32'h00000000, 6, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'h0};
    tv[10] = '{32'h0210909B, 64'h1000, 32'h00000000, 6, 1, 64'h1, 5, 1, 64'h0};
    tv[11] = '{32'hFFFFF117, 64'h1000, 32'hFFFFF000, 3, 0, 64'hFFFF_FFFF_FFFF_F000, 3, 0, 64'h0};
    tv[12] = '{32'h800080E7, 64'h1000, 32'hFFFFF800, 0, 0, 64'hFFFF_FFFF_FFFF_F800, 0, 0, 64'h0};
    tv[13] = '{32'hFFC12083, 64'h1000, 32'hFFFFFFFC, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h0};
    tv[14] = '{32'h002081BB, 64'h1000, 32'h00000000, 6, 1, 64'h0, 6, 0, 64'h0};
    tv[15] = '{32'h4050D093, 64'h1000, 32'h00000005, 5, 0, 64'h5, 5, 0, 64'h0};

    reset = 1'b1;
    drive(0, 32'h0, 64'h0, 0, 0);
    #3;
    chk("rst.out_valid", if32.out_valid, 0);
    chk("rst.out_instr", if32.out_instr, 0);
    chk("rst.out_imm", if64.out_imm, 0);
    chk("rst.out_pc", if64.out_pc, 0);
    chk("rst.out_fmt", if32.out_fmt, 0);
    chk("rst.out_illegal", if32.out_illegal, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst.in_ready_after", if32.in_ready, 1);
    chk("rst.out_valid_after", if64.out_valid, 0);

    // Back-to-back vectors, no backpressure: one result per cycle.
    for (int i = 0; i <= 16; i++) begin
      step();
      if (i < 16) drive(1, tv[i].instr, tv[i].pc, 1, 0);
      else drive(0, 32'h0, 64'h0, 1, 0);
      @(negedge clk);
      if (i > 0) begin
        chk("tv.out_valid32", if32.out_valid, 1);
        chk("tv.imm32", if32.out_imm, tv[i-1].imm32);
        chk("tv.fmt32", if32.out_fmt, tv[i-1].fmt32);
        chk("tv.ill32", if32.out_illegal, tv[i-1].ill32);
        chk("tv.out_valid64", if64.out_valid, 1);
        chk("tv.imm64", if64.out_imm, tv[i-1].imm64);
        chk("tv.fmt64", if64.out_fmt, tv[i-1].fmt64);
        chk("tv.ill64", if64.out_illegal, tv[i-1].ill64);
`ifdef IMM_TARGET_CALC_EN
        chk("tv.tgt32", if32.out_target, tv[i-1].tgt & 64'hFFFF_FFFF);
        chk("tv.tgt64", if64.out_target, tv[i-1].tgt);
`endif
      end
    end
    step();
    @(negedge clk);
    chk("tv.drained", if32.out_valid, 0);

    // Backpressure: third offer refused, output held, drains A,B,C in order.
    step(); drive(1, A, 64'h100, 0, 0);
    @(negedge clk); chk("bp.ready_empty", if32.in_ready, 1);
    step(); drive(1, B, 64'h104, 0, 0);
    @(negedge clk); chk("bp.m_holds_a", if32.out_instr, A); chk("bp.ready_one", if32.in_ready, 1);
    step(); drive(1, C, 64'h108, 0, 0);
    @(negedge clk); chk("bp.third_refused", if32.in_ready, 0); chk("bp.stable_a", if32.out_instr, A);
    step();
    @(negedge clk); chk("bp.stable_a2", if64.out_instr, A); chk("bp.stable_pc", if64.out_pc, 64'h100);
    step(); drive(1, C, 64'h108, 1, 0);
    @(negedge clk); chk("bp.release_a", if32.out_instr, A);
    step();
    @(negedge clk); chk("bp.order_b", if32.out_instr, B); chk("bp.ready_again", if32.in_ready, 1);
    step(); drive(0, 32'h0, 64'h0, 1, 0);
    @(negedge clk); chk("bp.order_c", if32.out_instr, C); chk("bp.c_valid", if32.out_valid, 1);
    step();
    @(negedge clk); chk("bp.empty", if32.out_valid, 0);

    // Flush with M and S full and an input offered.
    step(); drive(1, A, 64'h200, 0, 0);
    step(); drive(1, B, 64'h204, 0, 0);
    step(); drive(1, D, 64'h208, 0, 1);
    @(negedge clk); chk("fl.s_full", if32.in_ready, 0);
    step(); drive(0, 32'h0, 64'h0, 1, 0);
    @(negedge clk);
    chk("fl.out_valid32", if32.out_valid, 0); chk("fl.in_ready32", if32.in_ready, 1);
    chk("fl.out_valid64", if64.out_valid, 0); chk("fl.in_ready64", if64.in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk); chk("fl.no_ghost", if32.out_valid, 0);
    end
    // Flush with only M held while the stage could accept: offer is dropped.
    step(); drive(1, A, 64'h300, 0, 0);
    step(); drive(1, D, 64'h304, 1, 1);
    step(); drive(0, 32'h0, 64'h0, 1, 0);
    @(negedge clk); chk("fl2.dropped", if32.out_valid, 0); chk("fl2.in_ready", if32.in_ready, 1);
    step();
    @(negedge clk); chk("fl2.dropped_later", if64.out_valid, 0);

    // Asynchronous reset between edges with two entries held.
    step(); drive(1, A, 64'h400, 0, 0);
    step(); drive(1, B, 64'h404, 0, 0);
    step(); drive(0, 32'h0, 64'h0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("ar.out_valid32", if32.out_valid, 0); chk("ar.out_valid64", if64.out_valid, 0);
    chk("ar.in_ready", if32.in_ready, 1); chk("ar.out_instr", if32.out_instr, 0);
    step(); reset = 1'b0; drive(0, 32'h0, 64'h0, 1, 0);
    @(negedge clk); chk("ar.after_valid", if32.out_valid, 0); chk("ar.after_ready", if64.in_ready, 1);

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      step();
      ri = $urandom;
      if ($urandom_range(7, 0) != 0) ri[6:0] = 7'(ops[$urandom_range(11, 0)]);
      drive($urandom_range(3, 0) != 0, ri, {$urandom, $urandom},
            $urandom_range(2, 0) != 0, $urandom_range(39, 0) == 0);
    end
    step(); drive(0, 32'h0, 64'h0, 1, 0);
    repeat (4) step();
    @(negedge clk);
    chk("end.q32_empty", 64'(q32.size()), 0);
    chk("end.q64_empty", 64'(q64.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
